// File: rtl/pcler_counter_if.sv
// Interface for the loadable up/down counter: control/data toward the counter,
// count and status flags back.
interface pcler_counter_if #(
  parameter int WIDTH  = 8,
  parameter int WRAP_W = 4
);
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              en;
  logic              inhibit;
  logic              dir;
  logic              oneshot;
  logic [WIDTH-1:0]  reload_val;
  logic [WIDTH-1:0]  count;
  logic              tc;
  logic              wrap;
  logic              done;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (
    output load, load_val, en, inhibit, dir, oneshot, reload_val,
    input  count, tc, wrap, done, wrap_cnt
  );

  modport slave (
    input  load, load_val, en, inhibit, dir, oneshot, reload_val,
    output count, tc, wrap, done, wrap_cnt
  );
endinterface

// File: rtl/pcler_counter.sv
// Programmable timer/divider: loadable up/down counter that reloads or stops at
// terminal count, with a registered wrap pulse and a saturating wrap counter.
module pcler_counter #(
  parameter int WIDTH  = 8,
  parameter int WRAP_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  pcler_counter_if.slave bus
);

  typedef enum logic {
    RUN  = 1'b0,
    STOP = 1'b1
  } mode_t;

  mode_t             mode;
  logic [WIDTH-1:0]  count_q;
  logic              wrap_q;
  logic [WRAP_W-1:0] wrap_cnt_q;
  logic [WIDTH-1:0]  terminal;
  logic              active;
  logic              at_tc;

  // Terminal value follows the direction seen in this cycle, not a registered copy.
  assign terminal = bus.dir ? '0 : '1;
  assign active   = bus.en & ~bus.inhibit & ~bus.load & (mode == RUN);
  assign at_tc    = active & (count_q == terminal);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is synchronous, so it lives inside the edge.
    if (!rst_n) begin
      mode       <= RUN;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
    end else if (bus.load) begin
      mode       <= RUN;
      count_q    <= bus.load_val;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
    end else if (!active) begin
      wrap_q <= 1'b0;
    end else if (!at_tc) begin
      count_q <= bus.dir ? count_q - 1'b1 : count_q + 1'b1;
      wrap_q  <= 1'b0;
    end else if (!bus.oneshot) begin
      count_q <= bus.reload_val;
      wrap_q  <= 1'b1;
      if (wrap_cnt_q != '1) wrap_cnt_q <= wrap_cnt_q + 1'b1;
    end else begin
      // One-shot: park on the terminal value until the next load.
      mode   <= STOP;
      wrap_q <= 1'b0;
    end
  end

  assign bus.count    = count_q;
  assign bus.tc       = at_tc;
  assign bus.wrap     = wrap_q;
  assign bus.done     = (mode == STOP);
  assign bus.wrap_cnt = wrap_cnt_q;

endmodule
